// File: rtl/addn_seq_ctrl_pkg.sv
// Shared definitions for the byte-serial wide adder sequencer.
package addn_seq_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Two's complement overflow: like-signed operands giving an opposite-signed sum.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/addn_seq_ctrl_if.sv
// Requester-side handshake and operand/result bundle for addn_seq_ctrl.
interface addn_seq_ctrl_if #(
    parameter int unsigned NBYTES = 4
);
    import addn_seq_ctrl_pkg::*;

    localparam int unsigned W = BYTE_W * NBYTES;

    logic         start;
    logic         cin;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output start, cin, op_a, op_b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, cin, op_a, op_b,
        output busy, done, result, cout, ovf
    );

endinterface

// File: rtl/addn_seq_ctrl_add8_slice.sv
// Registered 8-bit add slice: {cout,sum} <= a + b + cin, synchronous clear.
module addn_seq_ctrl_add8_slice
    import addn_seq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    always_ff @(posedge clk) begin
        if (clr) begin
            {cout, sum} <= '0;
        end else begin
            {cout, sum} <= {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
        end
    end

endmodule

// File: rtl/addn_seq_ctrl.sv
// Wide adder sequencer: one registered byte slice, LSB first, carry rippled through the slice register.
module addn_seq_ctrl
    import addn_seq_ctrl_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic           clk_100M,
    input  logic           rst,
    addn_seq_ctrl_if.slave bus
);

    localparam int unsigned W     = BYTE_W * NBYTES;
    localparam int unsigned IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             cin_q, cin_d;
    logic [W-1:0]     res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [BYTE_W-1:0] sl_a, sl_b, sl_sum;
    logic              sl_cin, sl_cout;
    int unsigned       rd_lsb, wr_lsb;

    addn_seq_ctrl_add8_slice u_add8_slice (
        .clk  (clk_100M),
        .clr  (rst),
        .a    (sl_a),
        .b    (sl_b),
        .cin  (sl_cin),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        sl_a    = '0;
        sl_b    = '0;
        sl_cin  = 1'b0;
        rd_lsb  = BYTE_W * 32'(idx_q);
        wr_lsb  = BYTE_W * 32'(idx_q - IDX_W'(1));

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    cin_d   = bus.cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sl_a   = a_q[rd_lsb +: BYTE_W];
                sl_b   = b_q[rd_lsb +: BYTE_W];
                sl_cin = (idx_q == '0) ? cin_q : sl_cout;
                // Slice output lags one cycle, so this cycle's sum belongs to the previous byte.
                if (idx_q != '0) begin
                    res_d[wr_lsb +: BYTE_W] = sl_sum;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                res_d[BYTE_W*(NBYTES-1) +: BYTE_W] = sl_sum;
                cout_d  = sl_cout;
                ovf_d   = signed_ovf(a_q[W-1], b_q[W-1], sl_sum[BYTE_W-1]);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = res_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_addn_seq_ctrl.sv
// Scoreboard bench for addn_seq_ctrl (NBYTES=4): timing model pushes expected sums on accept, popped on done.
module tb_addn_seq_ctrl;

    localparam int unsigned NBYTES = 4;
    localparam int unsigned W      = 8 * NBYTES;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk_100M = 1'b0;
    logic rst;

    always #5 clk_100M = ~clk_100M;

    addn_seq_ctrl_if #(.NBYTES(NBYTES)) bus ();

    addn_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .clk_100M (clk_100M),
        .rst      (rst),
        .bus      (bus)
    );

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cnt = 0;
    logic        done_exp = 1'b0;
    logic        mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] s;
        exp_t       e;
        s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.res  = s[W-1:0];
        e.cout = s[W];
        e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return e;
    endfunction

    // Timing model: accept from IDLE (incl. done cycle), done after NBYTES+1 further edges.
    always @(posedge clk_100M) begin
        if (rst) begin
            cnt      = 0;
            done_exp = 1'b0;
            sb.delete();
        end else begin
            done_exp = (cnt == 1);
            if (cnt != 0) begin
                cnt = cnt - 1;
            end else if (bus.start) begin
                sb.push_back(ref_add(bus.op_a, bus.op_b, bus.cin));
                cnt = NBYTES + 1;
            end
        end
    end

    always @(negedge clk_100M) begin
        exp_t e;
        if (mon_en) begin
            check("busy", 64'(bus.busy), 64'(cnt != 0));
            check("done", 64'(bus.done), 64'(done_exp));
            if (done_exp) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("result", 64'(bus.result), 64'(e.res));
                    check("cout", 64'(bus.cout), 64'(e.cout));
                    check("ovf", 64'(bus.ovf), 64'(e.ovf));
                end
            end
        end
    end

    // Called at a negedge with the DUT idle or in its done cycle; returns in the done cycle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = c;
        @(negedge clk_100M);
        bus.start = 1'b0;
        bus.op_a  = ~a;
        bus.op_b  = ~b;
        for (int unsigned i = 0; i < 20 && cnt != 0; i++) begin
            @(negedge clk_100M);
        end
        check("op_idle", 64'(cnt == 0), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.cin   = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (3) @(negedge clk_100M);
        mon_en = 1'b1;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_result", 64'(bus.result), 64'(0));
        check("rst_cout", 64'(bus.cout), 64'(0));
        check("rst_ovf", 64'(bus.ovf), 64'(0));
        rst = 1'b0;
        @(negedge clk_100M);

        // T1..T3: directed carry/overflow corners
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check("t1_result", 64'(bus.result), 64'(32'h0000_0000));
        check("t1_cout", 64'(bus.cout), 64'(1));
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check("t2_result", 64'(bus.result), 64'(32'h8000_0000));
        check("t2_ovf", 64'(bus.ovf), 64'(1));
        do_op(32'h0000_0000, 32'h0000_0000, 1'b1);
        check("t3a_result", 64'(bus.result), 64'(32'h0000_0001));
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        check("t3b_cout", 64'(bus.cout), 64'(1));
        check("t3b_ovf", 64'(bus.ovf), 64'(1));
        @(negedge clk_100M);

        // T4: start held, operands changing every cycle
        for (int unsigned i = 0; i < 40; i++) begin
            bus.start = 1'b1;
            bus.op_a  = $urandom;
            bus.op_b  = $urandom;
            bus.cin   = 1'($urandom_range(0, 1));
            @(negedge clk_100M);
        end
        bus.start = 1'b0;
        for (int unsigned i = 0; i < 20 && cnt != 0; i++) begin
            @(negedge clk_100M);
        end
        check("t4_idle", 64'(cnt == 0), 64'(1));
        repeat (2) @(negedge clk_100M);

        // T5: reset in the second RUN cycle, with start asserted alongside it
        bus.start = 1'b1;
        bus.op_a  = 32'h1234_5678;
        bus.op_b  = 32'h1111_1111;
        bus.cin   = 1'b0;
        @(negedge clk_100M);
        bus.start = 1'b0;
        @(negedge clk_100M);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(negedge clk_100M);
        check("t5_busy", 64'(bus.busy), 64'(0));
        check("t5_done", 64'(bus.done), 64'(0));
        check("t5_result", 64'(bus.result), 64'(0));
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (8) @(negedge clk_100M);
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0);
        check("t5_new_result", 64'(bus.result), 64'(32'h2345_6789));

        // T6: random back-to-back ops
        for (int unsigned i = 0; i < 1000; i++) begin
            do_op($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        repeat (3) @(negedge clk_100M);
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
